// File: rtl/vector_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vector_pipe_pkg
// Description : Shared encodings, instruction field positions and the packed
//               control bundle for the vector filter pipeline controller.
// Revision    : 1.0 - initial release
// ============================================================================
package vector_pipe_pkg;

    // Major opcode, InstrD[17:16]
    localparam logic [1:0] OP_ALU = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_VS  = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    // ALU operand B select
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_SCALAR = 2'b10;

    // Immediate extender format
    localparam logic [1:0] IMM_ALU = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_VS  = 2'b10;

    // Operand forwarding selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Instruction field bit positions
    localparam int RD_MSB = 27;
    localparam int RD_LSB = 24;
    localparam int RN_MSB = 23;
    localparam int RN_LSB = 20;
    localparam int RM_MSB = 3;
    localparam int RM_LSB = 0;
    localparam int OP_MSB = 17;
    localparam int OP_LSB = 16;
    localparam int FN_MSB = 15;
    localparam int FN_LSB = 13;
    localparam int I_BIT  = 12;
    localparam int L_BIT  = 11;

    // Datapath controls that travel down the pipeline.
    // alu_control is the funct field directly:
    // 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl, 110 shr, 111 mul
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic [2:0] alu_control;
        logic [1:0] alu_src;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/vector_hazard_logic.sv
`default_nettype none
// ============================================================================
// Module      : vector_hazard_logic
// Description : Combinational ALU-operand forwarding selects and load-use
//               stall detection for the vector pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_hazard_logic
    import vector_pipe_pkg::*;
#(
    parameter int REG_AW = 4
) (
    input  logic [REG_AW-1:0] i_ra1_d,
    input  logic [REG_AW-1:0] i_ra2_d,
    input  logic [REG_AW-1:0] i_ra1_e,
    input  logic [REG_AW-1:0] i_ra2_e,
    input  logic [REG_AW-1:0] i_wa3_e,
    input  logic              i_mem_to_reg_e,
    input  logic [REG_AW-1:0] i_wa3_m,
    input  logic              i_reg_write_m,
    input  logic [REG_AW-1:0] i_wa3_w,
    input  logic              i_reg_write_w,
    output logic [1:0]        o_forward_a_e,
    output logic [1:0]        o_forward_b_e,
    output logic              o_ldr_stall
);

    // Operand A: the younger M-stage result takes priority over W
    always_comb begin
        o_forward_a_e = FWD_RF;
        if (i_reg_write_m && (i_ra1_e == i_wa3_m)) begin
            o_forward_a_e = FWD_MEM;
        end else if (i_reg_write_w && (i_ra1_e == i_wa3_w)) begin
            o_forward_a_e = FWD_WB;
        end
    end

    // Operand B: same priority scheme on the second read address
    always_comb begin
        o_forward_b_e = FWD_RF;
        if (i_reg_write_m && (i_ra2_e == i_wa3_m)) begin
            o_forward_b_e = FWD_MEM;
        end else if (i_reg_write_w && (i_ra2_e == i_wa3_w)) begin
            o_forward_b_e = FWD_WB;
        end
    end

    // A load in E cannot forward to the instruction in D; decode addresses
    // are compared regardless of the D-stage opcode.
    assign o_ldr_stall = i_mem_to_reg_e && ((i_ra1_d == i_wa3_e) || (i_ra2_d == i_wa3_e));

endmodule
`default_nettype wire

// File: rtl/vector_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vector_pipe_ctrl
// Description : Decode, E/M/W control pipeline and hazard control for the
//               5-stage 8-lane vector filter pipeline.
//               Optional macro STALL_COUNT_EN enables a saturating counter of
//               load-use stall cycles on StallCount (otherwise tied to 0).
// Revision    : 1.0 - initial release
// ============================================================================
module vector_pipe_ctrl
    import vector_pipe_pkg::*;
#(
    parameter int REG_AW  = 4,
    parameter int INSTR_W = 28
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [INSTR_W-1:0] InstrD,
    output logic               RegWriteE,
    output logic               RegWriteM,
    output logic               RegWriteW,
    output logic               MemWriteE,
    output logic               MemWriteM,
    output logic               MemtoRegE,
    output logic               MemtoRegW,
    output logic [2:0]         ALUControlE,
    output logic [1:0]         ALUSrcE,
    output logic [1:0]         ImmSrcD,
    output logic [REG_AW-1:0]  RA1D,
    output logic [REG_AW-1:0]  RA2D,
    output logic [REG_AW-1:0]  WA3W,
    output logic [1:0]         ForwardAE,
    output logic [1:0]         ForwardBE,
    output logic               StallF,
    output logic               StallD,
    output logic               FlushE,
    output logic [15:0]        StallCount
);

    logic [REG_AW-1:0] w_rd;
    logic [REG_AW-1:0] w_rn;
    logic [REG_AW-1:0] w_rm;
    logic [1:0]        w_op;
    logic [2:0]        w_funct;
    logic              w_i;
    logic              w_l;
    logic              w_reg_src;
    logic              w_ldr_stall;
    logic              w_unused_bits;
    ctrl_t             w_ctrl_d;

    ctrl_t             r_ctrl_e;
    logic [REG_AW-1:0] r_ra1_e;
    logic [REG_AW-1:0] r_ra2_e;
    logic [REG_AW-1:0] r_wa3_e;
    logic              r_reg_write_m;
    logic              r_mem_write_m;
    logic              r_mem_to_reg_m;
    logic [REG_AW-1:0] r_wa3_m;
    logic              r_reg_write_w;
    logic              r_mem_to_reg_w;
    logic [REG_AW-1:0] r_wa3_w;

    assign w_rd    = InstrD[RD_MSB:RD_LSB];
    assign w_rn    = InstrD[RN_MSB:RN_LSB];
    assign w_rm    = InstrD[RM_MSB:RM_LSB];
    assign w_op    = InstrD[OP_MSB:OP_LSB];
    assign w_funct = InstrD[FN_MSB:FN_LSB];
    assign w_i     = InstrD[I_BIT];
    assign w_l     = InstrD[L_BIT];

    // Bits not decoded by this block (immediate payload, reserved)
    assign w_unused_bits = ^{InstrD[19:18], InstrD[10:4]};

    // Decode the D-stage instruction into datapath controls
    always_comb begin
        w_ctrl_d  = '0;
        ImmSrcD   = IMM_ALU;
        w_reg_src = 1'b0;
        case (w_op)
            OP_ALU: begin
                w_ctrl_d.reg_write   = 1'b1;
                w_ctrl_d.alu_src     = w_i ? SRCB_IMM : SRCB_REG;
                w_ctrl_d.alu_control = w_funct;
            end
            OP_MEM: begin
                w_ctrl_d.alu_src = SRCB_IMM;
                ImmSrcD          = IMM_MEM;
                if (w_l) begin
                    w_ctrl_d.reg_write  = 1'b1;
                    w_ctrl_d.mem_to_reg = 1'b1;
                end else begin
                    // Store data comes from Rd, read on port 2
                    w_ctrl_d.mem_write = 1'b1;
                    w_reg_src          = 1'b1;
                end
            end
            OP_VS: begin
                w_ctrl_d.reg_write   = 1'b1;
                w_ctrl_d.alu_src     = SRCB_SCALAR;
                w_ctrl_d.alu_control = w_funct;
                ImmSrcD              = IMM_VS;
            end
            default: begin
                // NOP: everything stays cleared
            end
        endcase
    end

    assign RA1D = w_rn;
    assign RA2D = w_reg_src ? w_rd : w_rm;

    // D->E register; a flush inserts a bubble with cleared enables/addresses
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ctrl_e <= '0;
            r_ra1_e  <= '0;
            r_ra2_e  <= '0;
            r_wa3_e  <= '0;
        end else if (w_ldr_stall) begin
            r_ctrl_e <= '0;
            r_ra1_e  <= '0;
            r_ra2_e  <= '0;
            r_wa3_e  <= '0;
        end else begin
            r_ctrl_e <= w_ctrl_d;
            r_ra1_e  <= RA1D;
            r_ra2_e  <= RA2D;
            r_wa3_e  <= w_rd;
        end
    end

    // E->M and M->W registers advance every cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_reg_write_m  <= 1'b0;
            r_mem_write_m  <= 1'b0;
            r_mem_to_reg_m <= 1'b0;
            r_wa3_m        <= '0;
            r_reg_write_w  <= 1'b0;
            r_mem_to_reg_w <= 1'b0;
            r_wa3_w        <= '0;
        end else begin
            r_reg_write_m  <= r_ctrl_e.reg_write;
            r_mem_write_m  <= r_ctrl_e.mem_write;
            r_mem_to_reg_m <= r_ctrl_e.mem_to_reg;
            r_wa3_m        <= r_wa3_e;
            r_reg_write_w  <= r_reg_write_m;
            r_mem_to_reg_w <= r_mem_to_reg_m;
            r_wa3_w        <= r_wa3_m;
        end
    end

    assign RegWriteE   = r_ctrl_e.reg_write;
    assign MemWriteE   = r_ctrl_e.mem_write;
    assign MemtoRegE   = r_ctrl_e.mem_to_reg;
    assign ALUControlE = r_ctrl_e.alu_control;
    assign ALUSrcE     = r_ctrl_e.alu_src;
    assign RegWriteM   = r_reg_write_m;
    assign MemWriteM   = r_mem_write_m;
    assign RegWriteW   = r_reg_write_w;
    assign MemtoRegW   = r_mem_to_reg_w;
    assign WA3W        = r_wa3_w;

    vector_hazard_logic #(
        .REG_AW (REG_AW)
    ) u_hazard (
        .i_ra1_d        (RA1D),
        .i_ra2_d        (RA2D),
        .i_ra1_e        (r_ra1_e),
        .i_ra2_e        (r_ra2_e),
        .i_wa3_e        (r_wa3_e),
        .i_mem_to_reg_e (r_ctrl_e.mem_to_reg),
        .i_wa3_m        (r_wa3_m),
        .i_reg_write_m  (r_reg_write_m),
        .i_wa3_w        (r_wa3_w),
        .i_reg_write_w  (r_reg_write_w),
        .o_forward_a_e  (ForwardAE),
        .o_forward_b_e  (ForwardBE),
        .o_ldr_stall    (w_ldr_stall)
    );

    assign StallF = w_ldr_stall;
    assign StallD = w_ldr_stall;
    assign FlushE = w_ldr_stall;

`ifdef STALL_COUNT_EN
    logic [15:0] r_stall_count;

    // Count load-use stall cycles, holding at all-ones
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stall_count <= 16'h0000;
        end else if (w_ldr_stall && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'h0001;
        end
    end

    assign StallCount = r_stall_count;
`else
    assign StallCount = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vector_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_pipe_ctrl
// Description : Self-checking bench for vector_pipe_ctrl. Expected E-stage
//               controls are queued when an instruction is driven into D and
//               compared when that instruction reaches E.
//               Note: only MemtoRegE gates the load-use stall; a NOP in D still
//               has its address fields compared, so scenarios keep NOP fields
//               (all zero) away from load destinations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_pipe_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [27:0] InstrD;
    logic        RegWriteE, RegWriteM, RegWriteW;
    logic        MemWriteE, MemWriteM;
    logic        MemtoRegE, MemtoRegW;
    logic [2:0]  ALUControlE;
    logic [1:0]  ALUSrcE, ImmSrcD;
    logic [3:0]  RA1D, RA2D, WA3W;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, FlushE;
    logic [15:0] StallCount;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic       rw;
        logic       mw;
        logic       m2r;
        logic [2:0] aluc;
        logic [1:0] alusrc;
        logic [1:0] imm;
        logic [3:0] ra1;
        logic [3:0] ra2;
    } exp_t;

    exp_t q[$];

    localparam logic [27:0] NOP = 28'h0030000;

    vector_pipe_ctrl #(.REG_AW(4), .INSTR_W(28)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .InstrD      (InstrD),
        .RegWriteE   (RegWriteE),
        .RegWriteM   (RegWriteM),
        .RegWriteW   (RegWriteW),
        .MemWriteE   (MemWriteE),
        .MemWriteM   (MemWriteM),
        .MemtoRegE   (MemtoRegE),
        .MemtoRegW   (MemtoRegW),
        .ALUControlE (ALUControlE),
        .ALUSrcE     (ALUSrcE),
        .ImmSrcD     (ImmSrcD),
        .RA1D        (RA1D),
        .RA2D        (RA2D),
        .WA3W        (WA3W),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .StallF      (StallF),
        .StallD      (StallD),
        .FlushE      (FlushE),
        .StallCount  (StallCount)
    );

    always #5 CLK = ~CLK;

    function automatic logic [27:0] mk(input logic [1:0] op, input logic [2:0] fn,
                                       input logic i, input logic l,
                                       input logic [3:0] rd, input logic [3:0] rn,
                                       input logic [3:0] rm);
        logic [27:0] v;
        v        = '0;
        v[27:24] = rd;
        v[23:20] = rn;
        v[3:0]   = rm;
        v[17:16] = op;
        v[15:13] = fn;
        v[12]    = i;
        v[11]    = l;
        return v;
    endfunction

    // Reference decode taken from the instruction-set table
    function automatic exp_t model(input logic [27:0] ins);
        exp_t e;
        e     = '0;
        e.ra1 = ins[23:20];
        e.ra2 = ins[3:0];
        case (ins[17:16])
            2'b00: begin e.rw = 1; e.aluc = ins[15:13]; e.alusrc = ins[12] ? 2'b01 : 2'b00; end
            2'b01: begin
                e.alusrc = 2'b01; e.imm = 2'b01;
                if (ins[11]) begin e.rw = 1; e.m2r = 1; end
                else begin e.mw = 1; e.ra2 = ins[27:24]; end
            end
            2'b10: begin e.rw = 1; e.aluc = ins[15:13]; e.alusrc = 2'b10; e.imm = 2'b10; end
            default: begin end
        endcase
        return e;
    endfunction

    // One D-stage cycle: retire the oldest expectation at E, drive a new
    // instruction, queue its expectation and check the decode outputs.
    task automatic drive_cycle(input logic [27:0] ins, input string tag);
        exp_t e;
        exp_t x;
        @(negedge CLK);
        if (q.size() > 0) begin
            x = q.pop_front();
            n_checks++;
            if ({RegWriteE, MemWriteE, MemtoRegE, ALUControlE, ALUSrcE} !==
                {x.rw, x.mw, x.m2r, x.aluc, x.alusrc}) begin
                n_fail++;
                $display("FAIL %s E-ctrl: got %b expected %b", tag,
                         {RegWriteE, MemWriteE, MemtoRegE, ALUControlE, ALUSrcE},
                         {x.rw, x.mw, x.m2r, x.aluc, x.alusrc});
            end
        end
        InstrD = ins;
        e = model(ins);
        q.push_back(e);
        #1;
        n_checks++;
        if ({RA1D, RA2D, ImmSrcD} !== {e.ra1, e.ra2, e.imm}) begin
            n_fail++;
            $display("FAIL %s decode RA1/RA2/Imm: got %h/%h/%b expected %h/%h/%b", tag,
                     RA1D, RA2D, ImmSrcD, e.ra1, e.ra2, e.imm);
        end
    endtask

    task automatic flush_pipe();
        repeat (3) drive_cycle(NOP, "flush");
    endtask

    task automatic test_reset();
        logic [27:0] dep;
        RST = 1'b1;
        InstrD = NOP;
        repeat (2) @(negedge CLK);
        n_checks++;
        if ({RegWriteE, RegWriteM, RegWriteW, MemWriteE, MemWriteM, MemtoRegE, MemtoRegW,
             WA3W, ForwardAE, ForwardBE, StallF, StallD, FlushE, StallCount} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got nonzero outputs (RegWriteE=%b RegWriteM=%b StallF=%b StallCount=%0d) expected all zero",
                     RegWriteE, RegWriteM, StallF, StallCount);
        end
        RST = 1'b0;
        q.delete();
        // Run into a load-use stall, then reset asynchronously mid-cycle
        dep = mk(2'b00, 3'b000, 1'b0, 1'b0, 4'd8, 4'd5, 4'd1);
        drive_cycle(mk(2'b00, 3'b000, 1'b0, 1'b0, 4'd2, 4'd1, 4'd1), "rst_add");
        drive_cycle(mk(2'b01, 3'b000, 1'b1, 1'b1, 4'd5, 4'd6, 4'd0), "rst_load");
        drive_cycle(dep, "rst_dep");
        n_checks++;
        if (StallF !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_stall: got StallF=%b expected 1", StallF);
        end
        RST = 1'b1;
        #1;
        n_checks++;
        if ({RegWriteE, RegWriteM, RegWriteW, MemWriteE, MemWriteM, MemtoRegE, MemtoRegW,
             WA3W, ForwardAE, ForwardBE, StallF, StallD, FlushE, StallCount} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got RegWriteE=%b RegWriteM=%b MemtoRegE=%b StallF=%b expected all zero",
                     RegWriteE, RegWriteM, MemtoRegE, StallF);
        end
        q.delete();
        @(negedge CLK);
        RST = 1'b0;
        #1;
        n_checks++;
        if ({StallF, StallD, FlushE, ForwardAE, ForwardBE} !== 7'b0) begin
            n_fail++;
            $display("FAIL post_reset_no_stall: got %b expected 0000000",
                     {StallF, StallD, FlushE, ForwardAE, ForwardBE});
        end
        q.push_back(model(dep));
        drive_cycle(NOP, "post_reset");
        n_checks++;
        if ({ForwardAE, ForwardBE} !== 4'b0000) begin
            n_fail++;
            $display("FAIL post_reset_fwd: got %b/%b expected 00/00", ForwardAE, ForwardBE);
        end
    endtask

    task automatic test_decode();
        logic [27:0] tbl[5];
        flush_pipe();
        tbl[0] = mk(2'b00, 3'b000, 1'b1, 1'b0, 4'd1,  4'd2,  4'd3);   // add imm
        tbl[1] = mk(2'b00, 3'b100, 1'b0, 1'b0, 4'd10, 4'd11, 4'd12);  // xor reg
        tbl[2] = mk(2'b00, 3'b111, 1'b0, 1'b0, 4'd13, 4'd1,  4'd4);   // mul
        tbl[3] = mk(2'b10, 3'b110, 1'b0, 1'b0, 4'd14, 4'd15, 4'd6);   // vs shr
        tbl[4] = mk(2'b01, 3'b000, 1'b0, 1'b1, 4'd9,  4'd2,  4'd0);   // load
        for (int k = 0; k < 5; k++) drive_cycle(tbl[k], "decode");
        flush_pipe();
    endtask

    task automatic test_store();
        flush_pipe();
        drive_cycle(mk(2'b01, 3'b000, 1'b0, 1'b0, 4'd7, 4'd1, 4'd2), "store");
        n_checks++;
        if (RA2D !== 4'd7) begin
            n_fail++;
            $display("FAIL store_ra2: got %0d expected 7", RA2D);
        end
        drive_cycle(NOP, "store_e");
        n_checks++;
        if ({MemWriteE, RegWriteE, ALUSrcE} !== 4'b1001) begin
            n_fail++;
            $display("FAIL store_e: got MemWriteE=%b RegWriteE=%b ALUSrcE=%b expected 1/0/01",
                     MemWriteE, RegWriteE, ALUSrcE);
        end
        drive_cycle(NOP, "store_m");
        n_checks++;
        if ({MemWriteM, RegWriteM} !== 2'b10) begin
            n_fail++;
            $display("FAIL store_m: got MemWriteM=%b RegWriteM=%b expected 1/0", MemWriteM, RegWriteM);
        end
    endtask

    task automatic test_back_to_back();
        flush_pipe();
        drive_cycle(mk(2'b00, 3'b000, 1'b0, 1'b0, 4'd3, 4'd1, 4'd2), "b2b_add");
        drive_cycle(mk(2'b00, 3'b001, 1'b0, 1'b0, 4'd6, 4'd3, 4'd4), "b2b_sub");
        drive_cycle(mk(2'b00, 3'b100, 1'b0, 1'b0, 4'd7, 4'd8, 4'd3), "b2b_xor");
        n_checks++;
        if ({ForwardAE, ForwardBE} !== 4'b1000) begin
            n_fail++;
            $display("FAIL b2b_fwd_mem: got A=%b B=%b expected A=10 B=00", ForwardAE, ForwardBE);
        end
        drive_cycle(NOP, "b2b_nop");
        n_checks++;
        if ({ForwardAE, ForwardBE} !== 4'b0001) begin
            n_fail++;
            $display("FAIL b2b_fwd_wb: got A=%b B=%b expected A=00 B=01", ForwardAE, ForwardBE);
        end
        n_checks++;
        if ({RegWriteM, RegWriteW, WA3W} !== {1'b1, 1'b1, 4'd3}) begin
            n_fail++;
            $display("FAIL b2b_latency: got RegWriteM=%b RegWriteW=%b WA3W=%0d expected 1/1/3",
                     RegWriteM, RegWriteW, WA3W);
        end
    endtask

    task automatic test_dual_match();
        flush_pipe();
        drive_cycle(mk(2'b00, 3'b000, 1'b0, 1'b0, 4'd4, 4'd1, 4'd1), "dual_add");
        drive_cycle(mk(2'b00, 3'b011, 1'b1, 1'b0, 4'd4, 4'd2, 4'd2), "dual_or");
        drive_cycle(mk(2'b00, 3'b010, 1'b0, 1'b0, 4'd9, 4'd4, 4'd10), "dual_and");
        drive_cycle(NOP, "dual_nop");
        n_checks++;
        if ({ForwardAE, ForwardBE} !== 4'b1000) begin
            n_fail++;
            $display("FAIL dual_match: got A=%b B=%b expected A=10 B=00", ForwardAE, ForwardBE);
        end
    endtask

    // Load followed by a dependent instruction: one stall cycle, bubble in E
    task automatic load_use_event(input logic [3:0] rd, input logic use_rm, input string tag);
        logic [27:0] dep;
        dep = use_rm ? mk(2'b00, 3'b000, 1'b0, 1'b0, 4'd6, 4'd1, rd)
                     : mk(2'b00, 3'b000, 1'b0, 1'b0, 4'd6, rd, 4'd2);
        drive_cycle(mk(2'b01, 3'b000, 1'b0, 1'b1, rd, 4'd1, 4'd0), tag);
        drive_cycle(dep, tag);
        n_checks++;
        if ({StallF, StallD, FlushE} !== 3'b111) begin
            n_fail++;
            $display("FAIL %s stall_on: got %b expected 111", tag, {StallF, StallD, FlushE});
        end
        void'(q.pop_back());
        q.push_back('0);
        drive_cycle(dep, tag);
        n_checks++;
        if ({StallF, StallD, FlushE, RegWriteE, MemtoRegE} !== 5'b0) begin
            n_fail++;
            $display("FAIL %s bubble: got stall=%b RegWriteE=%b MemtoRegE=%b expected 000/0/0",
                     tag, {StallF, StallD, FlushE}, RegWriteE, MemtoRegE);
        end
    endtask

    task automatic test_load_use();
        flush_pipe();
        load_use_event(4'd5, 1'b0, "ldu");
        drive_cycle(NOP, "ldu_fwd");
        n_checks++;
        if ({ForwardAE, ForwardBE, MemtoRegW} !== 5'b01001) begin
            n_fail++;
            $display("FAIL ldu_fwd: got A=%b B=%b MemtoRegW=%b expected 01/00/1",
                     ForwardAE, ForwardBE, MemtoRegW);
        end
    endtask

    task automatic test_stall_count();
        logic [15:0] exp_cnt;
        @(negedge CLK);
        RST = 1'b1;
        InstrD = NOP;
        @(negedge CLK);
        RST = 1'b0;
        q.delete();
        load_use_event(4'd5,  1'b0, "cnt1");
        load_use_event(4'd11, 1'b1, "cnt2");
        load_use_event(4'd13, 1'b0, "cnt3");
        drive_cycle(NOP, "cnt_end");
`ifdef STALL_COUNT_EN
        exp_cnt = 16'd3;
`else
        exp_cnt = 16'd0;
`endif
        n_checks++;
        if (StallCount !== exp_cnt) begin
            n_fail++;
            $display("FAIL stall_count: got %0d expected %0d", StallCount, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_store();
        test_back_to_back();
        test_dual_match();
        test_load_use();
        test_stall_count();
        flush_pipe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
